// File: rtl/lap_stopwatch.sv
// Lap stopwatch: BCD M:SS.t timer counting up or down in 0.1 s ticks,
// with rising-edge controls, preset loading and a lap display freeze.
module lap_stopwatch #(
   parameter int CLK_DIV = 5,
   parameter int MAX_MIN = 9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Start,
   input  logic       Stop,
   input  logic       Lap,
   input  logic       Load,
   input  logic       Countdown,
   input  logic [3:0] Preset_Tenths,
   input  logic [3:0] Preset_Ones,
   input  logic [3:0] Preset_Tens,
   input  logic [3:0] Preset_Minutes,
   output logic [3:0] Tenths_Seconds,
   output logic [3:0] Ones_Seconds,
   output logic [3:0] Tens_Seconds,
   output logic [3:0] Minutes,
   output logic       Running,
   output logic       Lap_Active,
   output logic       Done,
   output logic       Wrap
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_PAUSED = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] PS_ONE  = PW'(1);
   localparam logic [3:0] MAX_MIN_V  = 4'(MAX_MIN);

   logic [1:0]    state_q, state_d;
   logic [PW-1:0] prescale_q, prescale_d;
   logic          mode_q, mode_d;
   logic          freeze_q, freeze_d;
   logic          wrap_q, wrap_d;
   logic          startPrev_q, stopPrev_q, lapPrev_q, loadPrev_q;
   logic [3:0]    cntTenths_q, cntOnes_q, cntTens_q, cntMins_q;
   logic [3:0]    cntTenths_d, cntOnes_d, cntTens_d, cntMins_d;
   logic [3:0]    lapTenths_q, lapOnes_q, lapTens_q, lapMins_q;
   logic [3:0]    lapTenths_d, lapOnes_d, lapTens_d, lapMins_d;
   logic [3:0]    upTenths, upOnes, upTens, upMins;
   logic [3:0]    dnTenths, dnOnes, dnTens, dnMins;
   logic [3:0]    clTenths, clOnes, clTens, clMins;
   logic          startEdge, stopEdge, lapEdge, loadEdge;
   logic          isZero, isOne, atMax;

   assign startEdge = Start & ~startPrev_q;
   assign stopEdge  = Stop  & ~stopPrev_q;
   assign lapEdge   = Lap   & ~lapPrev_q;
   assign loadEdge  = Load  & ~loadPrev_q;

   assign isZero = (cntMins_q == 4'd0) && (cntTens_q == 4'd0) && (cntOnes_q == 4'd0) && (cntTenths_q == 4'd0);
   assign isOne  = (cntMins_q == 4'd0) && (cntTens_q == 4'd0) && (cntOnes_q == 4'd0) && (cntTenths_q == 4'd1);
   assign atMax  = (cntMins_q == MAX_MIN_V) && (cntTens_q == 4'd5) && (cntOnes_q == 4'd9) && (cntTenths_q == 4'd9);

   // Preset digits limited to legal clock values before they are loaded
   always_comb begin
      clTenths = (Preset_Tenths  > 4'd9)      ? 4'd9      : Preset_Tenths;
      clOnes   = (Preset_Ones    > 4'd9)      ? 4'd9      : Preset_Ones;
      clTens   = (Preset_Tens    > 4'd5)      ? 4'd5      : Preset_Tens;
      clMins   = (Preset_Minutes > MAX_MIN_V) ? MAX_MIN_V : Preset_Minutes;
   end

   // Count value one tick later in each direction, with BCD carry and borrow
   always_comb begin
      upTenths = cntTenths_q + 4'd1;
      upOnes   = cntOnes_q;
      upTens   = cntTens_q;
      upMins   = cntMins_q;
      if (cntTenths_q == 4'd9) begin
         upTenths = 4'd0;
         upOnes   = cntOnes_q + 4'd1;
         if (cntOnes_q == 4'd9) begin
            upOnes = 4'd0;
            upTens = cntTens_q + 4'd1;
            if (cntTens_q == 4'd5) begin
               upTens = 4'd0;
               upMins = (cntMins_q == MAX_MIN_V) ? 4'd0 : cntMins_q + 4'd1;
            end
         end
      end
      dnTenths = cntTenths_q - 4'd1;
      dnOnes   = cntOnes_q;
      dnTens   = cntTens_q;
      dnMins   = cntMins_q;
      if (cntTenths_q == 4'd0) begin
         dnTenths = 4'd9;
         dnOnes   = cntOnes_q - 4'd1;
         if (cntOnes_q == 4'd0) begin
            dnOnes = 4'd9;
            dnTens = cntTens_q - 4'd1;
            if (cntTens_q == 4'd0) begin
               dnTens = 4'd5;
               dnMins = cntMins_q - 4'd1;
            end
         end
      end
   end

   // Control: Load beats Stop beats Start beats Lap; ticking continues in RUN
   always_comb begin
      state_d     = state_q;
      prescale_d  = prescale_q;
      mode_d      = mode_q;
      freeze_d    = freeze_q;
      wrap_d      = 1'b0;
      cntTenths_d = cntTenths_q;
      cntOnes_d   = cntOnes_q;
      cntTens_d   = cntTens_q;
      cntMins_d   = cntMins_q;
      lapTenths_d = lapTenths_q;
      lapOnes_d   = lapOnes_q;
      lapTens_d   = lapTens_q;
      lapMins_d   = lapMins_q;
      if (loadEdge && (state_q != ST_RUN)) begin
         cntTenths_d = clTenths;
         cntOnes_d   = clOnes;
         cntTens_d   = clTens;
         cntMins_d   = clMins;
         prescale_d  = '0;
         freeze_d    = 1'b0;
         state_d     = ST_IDLE;
      end else if (stopEdge && (state_q == ST_RUN)) begin
         state_d = ST_PAUSED;
      end else begin
         if (startEdge && ((state_q == ST_IDLE) || (state_q == ST_PAUSED)) && !(Countdown && isZero)) begin
            state_d = ST_RUN;
            mode_d  = Countdown;
            if (state_q == ST_IDLE) begin
               prescale_d = '0;
            end
         end else if (lapEdge) begin
            if ((state_q == ST_RUN) && !freeze_q) begin
               freeze_d    = 1'b1;
               lapTenths_d = cntTenths_q;
               lapOnes_d   = cntOnes_q;
               lapTens_d   = cntTens_q;
               lapMins_d   = cntMins_q;
            end else begin
               freeze_d = 1'b0;
            end
         end
         if (state_q == ST_RUN) begin
            if (prescale_q == PS_LAST) begin
               prescale_d = '0;
               if (!mode_q) begin
                  cntTenths_d = upTenths;
                  cntOnes_d   = upOnes;
                  cntTens_d   = upTens;
                  cntMins_d   = upMins;
                  wrap_d      = atMax;
               end else begin
                  cntTenths_d = dnTenths;
                  cntOnes_d   = dnOnes;
                  cntTens_d   = dnTens;
                  cntMins_d   = dnMins;
                  if (isOne) begin
                     state_d = ST_DONE;
                  end
               end
            end else begin
               prescale_d = prescale_q + PS_ONE;
            end
         end
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         prescale_q  <= '0;
         mode_q      <= 1'b0;
         freeze_q    <= 1'b0;
         wrap_q      <= 1'b0;
         startPrev_q <= 1'b0;
         stopPrev_q  <= 1'b0;
         lapPrev_q   <= 1'b0;
         loadPrev_q  <= 1'b0;
         cntTenths_q <= 4'd0;
         cntOnes_q   <= 4'd0;
         cntTens_q   <= 4'd0;
         cntMins_q   <= 4'd0;
         lapTenths_q <= 4'd0;
         lapOnes_q   <= 4'd0;
         lapTens_q   <= 4'd0;
         lapMins_q   <= 4'd0;
      end else begin
         state_q     <= state_d;
         prescale_q  <= prescale_d;
         mode_q      <= mode_d;
         freeze_q    <= freeze_d;
         wrap_q      <= wrap_d;
         startPrev_q <= Start;
         stopPrev_q  <= Stop;
         lapPrev_q   <= Lap;
         loadPrev_q  <= Load;
         cntTenths_q <= cntTenths_d;
         cntOnes_q   <= cntOnes_d;
         cntTens_q   <= cntTens_d;
         cntMins_q   <= cntMins_d;
         lapTenths_q <= lapTenths_d;
         lapOnes_q   <= lapOnes_d;
         lapTens_q   <= lapTens_d;
         lapMins_q   <= lapMins_d;
      end
   end

   assign Tenths_Seconds = freeze_q ? lapTenths_q : cntTenths_q;
   assign Ones_Seconds   = freeze_q ? lapOnes_q   : cntOnes_q;
   assign Tens_Seconds   = freeze_q ? lapTens_q   : cntTens_q;
   assign Minutes        = freeze_q ? lapMins_q   : cntMins_q;
   assign Running        = (state_q == ST_RUN);
   assign Done           = (state_q == ST_DONE);
   assign Lap_Active     = freeze_q;
   assign Wrap           = wrap_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Self-checking bench for lap_stopwatch: a time-in-tenths model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_lap_stopwatch;

   localparam int CLK_DIV = 4;
   localparam int MAX_MIN = 1;
   localparam int MAXT    = MAX_MIN * 600 + 599;
   localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_DONE = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       Start = 1'b0, Stop = 1'b0, Lap = 1'b0, Load = 1'b0, Countdown = 1'b0;
   logic [3:0] Preset_Tenths = 4'd0, Preset_Ones = 4'd0, Preset_Tens = 4'd0, Preset_Minutes = 4'd0;
   logic [3:0] Tenths_Seconds, Ones_Seconds, Tens_Seconds, Minutes;
   logic       Running, Lap_Active, Done, Wrap;

   int assertCount = 0;
   int failCount   = 0;

   // Model: time held as a plain count of tenths of a second
   int mState, mT, mSnap, mPhase, disp;
   bit mMode, mFrozen, mWrap, mInit = 1'b0;
   bit pStart, pStop, pLap, pLoad, sE, pE, lE, dE, wasRun;

   lap_stopwatch #(.CLK_DIV(CLK_DIV), .MAX_MIN(MAX_MIN)) dut (
      .clk(clk), .reset(reset), .Start(Start), .Stop(Stop), .Lap(Lap), .Load(Load),
      .Countdown(Countdown), .Preset_Tenths(Preset_Tenths), .Preset_Ones(Preset_Ones),
      .Preset_Tens(Preset_Tens), .Preset_Minutes(Preset_Minutes),
      .Tenths_Seconds(Tenths_Seconds), .Ones_Seconds(Ones_Seconds), .Tens_Seconds(Tens_Seconds),
      .Minutes(Minutes), .Running(Running), .Lap_Active(Lap_Active), .Done(Done), .Wrap(Wrap)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [7:0] actual, input int expected);
      assertCount++;
      if (actual !== 8'(expected)) begin
         failCount++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic s, input logic st, input logic lp, input logic ld, input int n);
      Start = s; Stop = st; Lap = lp; Load = ld;
      waitCycles(1);
      Start = 1'b0; Stop = 1'b0; Lap = 1'b0; Load = 1'b0;
      waitCycles(n);
   endtask

   function automatic int clampTotal();
      int m, t, o, f;
      m = (Preset_Minutes > MAX_MIN) ? MAX_MIN : int'(Preset_Minutes);
      t = (Preset_Tens > 5) ? 5 : int'(Preset_Tens);
      o = (Preset_Ones > 9) ? 9 : int'(Preset_Ones);
      f = (Preset_Tenths > 9) ? 9 : int'(Preset_Tenths);
      return m * 600 + t * 100 + o * 10 + f;
   endfunction

   // Advance the behavioural model on every rising clock edge
   always @(posedge clk) begin
      if (!reset) begin
         mState = S_IDLE; mT = 0; mSnap = 0; mPhase = 0;
         mMode = 0; mFrozen = 0; mWrap = 0;
         pStart = 0; pStop = 0; pLap = 0; pLoad = 0;
      end else begin
         sE = Start && !pStart; pE = Stop && !pStop; lE = Lap && !pLap; dE = Load && !pLoad;
         pStart = Start; pStop = Stop; pLap = Lap; pLoad = Load;
         mWrap = 0;
         wasRun = (mState == S_RUN);
         if (dE && !wasRun) begin
            mT = clampTotal(); mPhase = 0; mFrozen = 0; mState = S_IDLE;
         end else if (pE && wasRun) begin
            mState = S_PAUSED;
         end else begin
            if (sE && (mState == S_IDLE || mState == S_PAUSED) && !(Countdown && mT == 0)) begin
               if (mState == S_IDLE) mPhase = 0;
               mMode = Countdown;
               mState = S_RUN;
            end else if (lE) begin
               if (wasRun && !mFrozen) begin
                  mFrozen = 1; mSnap = mT;
               end else begin
                  mFrozen = 0;
               end
            end
            if (wasRun) begin
               if (mPhase == CLK_DIV - 1) begin
                  mPhase = 0;
                  if (!mMode) begin
                     if (mT == MAXT) begin
                        mT = 0; mWrap = 1;
                     end else begin
                        mT = mT + 1;
                     end
                  end else begin
                     mT = mT - 1;
                     if (mT == 0) mState = S_DONE;
                  end
               end else begin
                  mPhase = mPhase + 1;
               end
            end
         end
      end
      mInit = 1;
   end

   // Compare every DUT output against the model on each falling edge
   always @(negedge clk) begin
      if (mInit) begin
         disp = mFrozen ? mSnap : mT;
         checkOutput("model.Tenths", 8'(Tenths_Seconds), disp % 10);
         checkOutput("model.Ones", 8'(Ones_Seconds), (disp % 100) / 10);
         checkOutput("model.Tens", 8'(Tens_Seconds), (disp % 600) / 100);
         checkOutput("model.Minutes", 8'(Minutes), disp / 600);
         checkOutput("model.Running", 8'(Running), (mState == S_RUN) ? 1 : 0);
         checkOutput("model.Done", 8'(Done), (mState == S_DONE) ? 1 : 0);
         checkOutput("model.Lap_Active", 8'(Lap_Active), mFrozen ? 1 : 0);
         checkOutput("model.Wrap", 8'(Wrap), mWrap ? 1 : 0);
      end
   end

   // Directed scenarios with hand-computed literal expectations
   initial begin
      waitCycles(3);
      checkOutput("rst.Tenths", 8'(Tenths_Seconds), 0);
      checkOutput("rst.Ones", 8'(Ones_Seconds), 0);
      checkOutput("rst.Tens", 8'(Tens_Seconds), 0);
      checkOutput("rst.Minutes", 8'(Minutes), 0);
      checkOutput("rst.Running", 8'(Running), 0);
      checkOutput("rst.Lap_Active", 8'(Lap_Active), 0);
      checkOutput("rst.Done", 8'(Done), 0);
      checkOutput("rst.Wrap", 8'(Wrap), 0);
      reset = 1'b1;
      waitCycles(1);

      // Ten ticks of four cycles each reach 0:01.0
      applyStimulus(1, 0, 0, 0, 40);
      checkOutput("up40.Tenths", 8'(Tenths_Seconds), 0);
      checkOutput("up40.Ones", 8'(Ones_Seconds), 1);
      checkOutput("up40.Running", 8'(Running), 1);

      // Lap freezes 0:01.0 while five more ticks happen underneath
      applyStimulus(0, 0, 1, 0, 20);
      checkOutput("lap.Tenths", 8'(Tenths_Seconds), 0);
      checkOutput("lap.Ones", 8'(Ones_Seconds), 1);
      checkOutput("lap.Active", 8'(Lap_Active), 1);
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("unlap.Tenths", 8'(Tenths_Seconds), 5);
      checkOutput("unlap.Active", 8'(Lap_Active), 0);

      // Simultaneous Start and Stop pauses; resume keeps prescaler phase
      applyStimulus(1, 1, 0, 0, 10);
      checkOutput("pause.Running", 8'(Running), 0);
      checkOutput("pause.Tenths", 8'(Tenths_Seconds), 5);
      applyStimulus(1, 0, 0, 0, 1);
      checkOutput("resume1.Tenths", 8'(Tenths_Seconds), 5);
      waitCycles(1);
      checkOutput("resume2.Tenths", 8'(Tenths_Seconds), 6);

      // Freeze survives Stop, then Lap while paused releases it
      applyStimulus(0, 0, 1, 0, 0);
      applyStimulus(0, 1, 0, 0, 5);
      checkOutput("frzStop.Active", 8'(Lap_Active), 1);
      checkOutput("frzStop.Tenths", 8'(Tenths_Seconds), 6);
      checkOutput("frzStop.Running", 8'(Running), 0);
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("release.Active", 8'(Lap_Active), 0);

      // Out-of-range preset clamps to 0:59.9
      Preset_Minutes = 4'd0; Preset_Tens = 4'd7; Preset_Ones = 4'd10; Preset_Tenths = 4'd12;
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("clamp.Tenths", 8'(Tenths_Seconds), 9);
      checkOutput("clamp.Ones", 8'(Ones_Seconds), 9);
      checkOutput("clamp.Tens", 8'(Tens_Seconds), 5);
      checkOutput("clamp.Minutes", 8'(Minutes), 0);

      // Minutes clamp to MAX_MIN, then count up through rollover
      Preset_Minutes = 4'd9; Preset_Tens = 4'd5; Preset_Ones = 4'd9; Preset_Tenths = 4'd8;
      Countdown = 1'b0;
      applyStimulus(0, 0, 0, 1, 1);
      checkOutput("pre.Minutes", 8'(Minutes), 1);
      checkOutput("pre.Tenths", 8'(Tenths_Seconds), 8);
      applyStimulus(1, 0, 0, 0, 8);
      checkOutput("wrap.Minutes", 8'(Minutes), 0);
      checkOutput("wrap.Tens", 8'(Tens_Seconds), 0);
      checkOutput("wrap.Tenths", 8'(Tenths_Seconds), 0);
      checkOutput("wrap.Pulse", 8'(Wrap), 1);
      checkOutput("wrap.Running", 8'(Running), 1);
      waitCycles(1);
      checkOutput("wrap.PulseEnd", 8'(Wrap), 0);

      // Countdown from 0:00.3 finishes after three ticks
      applyStimulus(0, 1, 0, 0, 1);
      Preset_Minutes = 4'd0; Preset_Tens = 4'd0; Preset_Ones = 4'd0; Preset_Tenths = 4'd3;
      applyStimulus(0, 0, 0, 1, 1);
      Countdown = 1'b1;
      applyStimulus(1, 0, 0, 0, 12);
      checkOutput("down.Tenths", 8'(Tenths_Seconds), 0);
      checkOutput("down.Done", 8'(Done), 1);
      checkOutput("down.Running", 8'(Running), 0);
      applyStimulus(1, 0, 0, 0, 3);
      checkOutput("doneStart.Done", 8'(Done), 1);
      checkOutput("doneStart.Running", 8'(Running), 0);

      // Countdown start from zero is refused; count-up from zero is not
      Preset_Tenths = 4'd0;
      applyStimulus(0, 0, 0, 1, 1);
      applyStimulus(1, 0, 0, 0, 2);
      checkOutput("zeroDown.Running", 8'(Running), 0);
      Countdown = 1'b0;
      applyStimulus(1, 0, 0, 0, 6);
      checkOutput("zeroUp.Running", 8'(Running), 1);
      checkOutput("zeroUp.Tenths", 8'(Tenths_Seconds), 1);

      // Reset in the middle of a run returns everything to zero
      reset = 1'b0;
      waitCycles(1);
      reset = 1'b1;
      checkOutput("midRst.Tenths", 8'(Tenths_Seconds), 0);
      checkOutput("midRst.Running", 8'(Running), 0);
      waitCycles(3);
      checkOutput("postRst.Tenths", 8'(Tenths_Seconds), 0);
      checkOutput("postRst.Running", 8'(Running), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/lap_stopwatch.md
LAP_STOPWATCH -- requirements
Module: lap_stopwatch

Interface
REQ-001 Parameter CLK_DIV, default 5, clk cycles per 0.1 s tick (>=2).
REQ-002 Parameter MAX_MIN, default 9, highest Minutes value (1..15).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 Start  input  1  run request; acted on at rising edge of the signal.
REQ-006 Stop  input  1  pause request; acted on at rising edge.
REQ-007 Lap  input  1  display freeze toggle; acted on at rising edge.
REQ-008 Load  input  1  preset load; acted on at rising edge.
REQ-009 Countdown  input  1  1 = count down, 0 = count up; sampled only on leaving IDLE/PAUSED/DONE.
REQ-010 Preset_Tenths, Preset_Ones, Preset_Tens, Preset_Minutes  input  4 each  BCD preset value.
REQ-011 Tenths_Seconds, Ones_Seconds, Tens_Seconds, Minutes  output  4 each  displayed BCD time.
REQ-012 Running  output  1  high in RUN.
REQ-013 Lap_Active  output  1  high while display is frozen.
REQ-014 Done  output  1  high in DONE.
REQ-015 Wrap  output  1  one-cycle pulse on count-up rollover.

Function
REQ-016 Edge detect: input rising edge = current 1, previous registered sample 0; the action takes effect at that clock edge and is visible the next cycle.
REQ-017 States IDLE, RUN, PAUSED, DONE; priority per cycle: Load > Stop > Start > Lap.
REQ-018 IDLE/PAUSED + Start -> RUN, latch Countdown into mode; Start in countdown with count 0:00.0 ignored.
REQ-019 RUN + Stop -> PAUSED; Start and Stop edges same cycle -> Stop wins.
REQ-020 DONE + Start -> RUN only after Load (nonzero count); otherwise ignored.
REQ-021 Load in IDLE/PAUSED/DONE: count := clamped preset, prescaler := 0, lap freeze cleared, state -> IDLE; Load in RUN ignored.
REQ-022 Clamp: any digit >9 -> 9, Tens >5 -> 5, Minutes >MAX_MIN -> MAX_MIN.
REQ-023 Prescaler counts 0..CLK_DIV-1 only in RUN; tick when at CLK_DIV-1, then returns to 0; held in PAUSED; cleared on entry to RUN from IDLE/DONE.
REQ-024 Up mode tick: tenths +1 with BCD carry 9->0 into ones, ones 9->0 into tens, tens 5->0 into minutes.
REQ-025 Up mode at MAX_MIN:59.9 tick -> 0:00.0, Wrap high one cycle, stays RUN.
REQ-026 Down mode tick: tenths -1 with borrow 0->9, ones 0->9, tens 0->5, minutes -1.
REQ-027 Down mode tick reaching 0:00.0 -> DONE same edge, Done high, count held.
REQ-028 Lap edge in RUN: toggles freeze; frozen outputs hold count at the edge; internal count continues.
REQ-029 Lap edge outside RUN while frozen releases freeze; while not frozen, ignored.
REQ-030 Unfrozen outputs equal internal count combinationally-registered with zero extra latency (same cycle as count register).
REQ-031 Stop while frozen keeps display frozen.

Reset
REQ-032 reset low at clk edge: state IDLE, count 0:00.0, prescaler 0, freeze clear, edge registers 0, mode up.
REQ-033 Reset outputs: all BCD outputs 0, Running 0, Lap_Active 0, Done 0, Wrap 0.
REQ-034 Reset overrides every other input, including mid-RUN and mid-Load.

Verification (CLK_DIV=4, MAX_MIN=1)
REQ-035 Release reset, Start pulse, 40 cycles -> Tenths=0, Ones=1, Running=1.
REQ-036 Up count from 1:59.8 preset, Start, 8 cycles -> 0:00.0, Wrap one-cycle pulse, Running=1.
REQ-037 Load preset 0:00.3, Countdown=1, Start -> after 12 cycles 0:00.0, Done=1, Running=0; further Start ignored.
REQ-038 RUN, Lap at 0:01.0, 20 more cycles -> outputs hold 0:01.0, Lap_Active=1; second Lap -> outputs 0:01.5.
REQ-039 Start and Stop rising same cycle in RUN -> PAUSED, count frozen; Start later resumes with prescaler phase kept.
REQ-040 Preset 0:7A.C (Ones=10, Tens=7, Tenths=12), Load -> count 0:59.9 after clamping.
